// File: rtl/regfile_mp.sv
// regfile_mp: multi-port GPR file with busy scoreboard, r0 hardwired to zero.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to the read ports.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREAD  = 2,
  parameter int NWRITE = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NWRITE-1:0]        we,
  input  logic [NWRITE*ADDR_W-1:0] waddr,
  input  logic [NWRITE*DATA_W-1:0] wdata,
  input  logic [NREAD-1:0]         re,
  input  logic [NREAD*ADDR_W-1:0]  raddr,
  output logic [NREAD*DATA_W-1:0]  rdata,
  output logic [NREAD-1:0]         rbusy,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;

  // issue is applied after clears so a new producer wins
  always_comb begin
    busy_d = busy_q;
    for (int a = 1; a < DEPTH; a++) begin
      for (int i = 0; i < NWRITE; i++) begin
        if (we[i] && waddr[i*ADDR_W +: ADDR_W] == ADDR_W'(a))
          busy_d[a] = 1'b0;
      end
      if (iss_valid && iss_addr == ADDR_W'(a))
        busy_d[a] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_comb begin
    cnt_d = '0;
    for (int a = 0; a < DEPTH; a++)
      cnt_d = cnt_d + {{ADDR_W{1'b0}}, busy_d[a]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
      for (int a = 0; a < DEPTH; a++)
        mem_q[a] <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      for (int i = 0; i < NWRITE; i++) begin
        if (we[i] && waddr[i*ADDR_W +: ADDR_W] != '0)
          mem_q[waddr[i*ADDR_W +: ADDR_W]] <= wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign busy_cnt = cnt_q;

  logic [ADDR_W-1:0] ra;
  logic [DATA_W-1:0] rd;
  logic              rb;
`ifdef REGFILE_BYPASS_EN
  logic              hit;
`endif

  always_comb begin
    rdata = '0;
    rbusy = '0;
    ra    = '0;
    rd    = '0;
    rb    = 1'b0;
`ifdef REGFILE_BYPASS_EN
    hit   = 1'b0;
`endif
    for (int j = 0; j < NREAD; j++) begin
      ra = raddr[j*ADDR_W +: ADDR_W];
      rd = mem_q[ra];
      rb = busy_q[ra];
`ifdef REGFILE_BYPASS_EN
      hit = 1'b0;
      for (int i = 0; i < NWRITE; i++) begin
        if (we[i] && waddr[i*ADDR_W +: ADDR_W] == ra) begin
          rd  = wdata[i*DATA_W +: DATA_W];
          hit = 1'b1;
        end
      end
      if (hit && !(iss_valid && iss_addr == ra))
        rb = 1'b0;
`endif
      if (!rst && re[j] && ra != '0) begin
        rdata[j*DATA_W +: DATA_W] = rd;
        rbusy[j] = rb;
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed + random stimulus against an array-based model.
// Runs with or without REGFILE_BYPASS_EN.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [NW-1:0]   we;
  logic [NW*AW-1:0] waddr;
  logic [NW*DW-1:0] wdata;
  logic [NR-1:0]   re;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic [NR-1:0]   rbusy;
  logic            iss_valid;
  logic [AW-1:0]   iss_addr;
  logic [AW:0]     busy_cnt;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR), .NWRITE(NW)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  int unsigned m_mem [32];
  bit          m_busy [32];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int m_count();
    int n = 0;
    for (int a = 0; a < 32; a++) n += int'(m_busy[a]);
    return n;
  endfunction

  // Model update: reset wipes everything, otherwise clears then issue.
  always @(posedge clk) begin
    if (rst) begin
      for (int a = 0; a < 32; a++) begin
        m_mem[a] = 0;
        m_busy[a] = 0;
      end
      chk_en = 1;
    end else begin
      for (int i = 0; i < NW; i++) begin
        int a;
        a = int'(waddr[i*AW +: AW]);
        if (we[i] && a != 0) begin
          m_mem[a] = wdata[i*DW +: DW];
          m_busy[a] = 0;
        end
      end
      if (iss_valid && iss_addr != 0) m_busy[iss_addr] = 1;
    end
  end

  // Compare process: outputs checked every cycle once state is known.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int j = 0; j < NR; j++) begin
        int a;
        int unsigned d;
        bit b;
        bit hit;
        a = int'(raddr[j*AW +: AW]);
        d = m_mem[a];
        b = m_busy[a];
        hit = 0;
`ifdef REGFILE_BYPASS_EN
        for (int i = 0; i < NW; i++) begin
          if (we[i] && int'(waddr[i*AW +: AW]) == a) begin
            d = wdata[i*DW +: DW];
            hit = 1;
          end
        end
        if (hit && !(iss_valid && int'(iss_addr) == a)) b = 0;
`endif
        if (rst || !re[j] || a == 0) begin
          d = 0;
          b = 0;
        end
        chk($sformatf("rdata[%0d]", j), 64'(rdata[j*DW +: DW]), 64'(d));
        chk($sformatf("rbusy[%0d]", j), 64'(rbusy[j]), 64'(b));
      end
      chk("busy_cnt", 64'(busy_cnt), 64'(m_count()));
    end
  end

  task automatic idle();
    we = '0; waddr = '0; wdata = '0;
    re = '0; raddr = '0;
    iss_valid = 0; iss_addr = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int p, input int a, input int unsigned d);
    we[p] = 1;
    waddr[p*AW +: AW] = AW'(a);
    wdata[p*DW +: DW] = d;
  endtask

  task automatic rd(input int p, input int a);
    re[p] = 1;
    raddr[p*AW +: AW] = AW'(a);
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst = 1;
    cyc();
    rst = 0;
    sample();
    chk("lit_cnt_reset", 64'(busy_cnt), 64'd0);

    // r0 is hardwired
    cyc(); idle();
    wr(0, 0, 32'hDEADBEEF); rd(0, 0); rd(1, 0);
    sample();
    chk("lit_r0_p0", 64'(rdata[0 +: DW]), 64'd0);
    chk("lit_r0_p1", 64'(rdata[DW +: DW]), 64'd0);
    cyc(); idle();
    rd(0, 0); rd(1, 0);
    sample();
    chk("lit_r0_after", 64'(rdata), 64'd0);
    chk("lit_r0_busy", 64'(rbusy), 64'd0);

    // reset discards earlier write
    cyc(); idle();
    wr(0, 5, 32'h12);
    cyc(); idle();
    rst = 1; rd(0, 5);
    cyc();
    rst = 0;
    sample();
    chk("lit_r5_reset", 64'(rdata[0 +: DW]), 64'd0);
    chk("lit_cnt_r5", 64'(busy_cnt), 64'd0);

    // port 1 wins
    cyc(); idle();
    wr(0, 7, 32'h1111); wr(1, 7, 32'h2222);
    cyc(); idle();
    rd(0, 7);
    sample();
    chk("lit_wprio", 64'(rdata[0 +: DW]), 64'h2222);

    // bypass
    cyc(); idle();
    wr(0, 3, 32'hA5A5A5A5); rd(1, 3);
    sample();
`ifdef REGFILE_BYPASS_EN
    chk("lit_bypass", 64'(rdata[DW +: DW]), 64'hA5A5A5A5);
`else
    chk("lit_nobypass", 64'(rdata[DW +: DW]), 64'd0);
`endif
    cyc(); idle();
    rd(1, 3);
    sample();
    chk("lit_r3_next", 64'(rdata[DW +: DW]), 64'hA5A5A5A5);

    // scoreboard set/clear
    cyc(); idle();
    iss_valid = 1; iss_addr = 9;
    cyc(); idle();
    rd(0, 9);
    sample();
    chk("lit_r9_busy", 64'(rbusy[0]), 64'd1);
    chk("lit_r9_cnt", 64'(busy_cnt), 64'd1);
    cyc(); idle();
    wr(1, 9, 32'h55);
    cyc(); idle();
    rd(0, 9);
    sample();
    chk("lit_r9_clr", 64'(rbusy[0]), 64'd0);
    chk("lit_r9_cnt0", 64'(busy_cnt), 64'd0);
    chk("lit_r9_data", 64'(rdata[0 +: DW]), 64'h55);

    // issue beats clear
    cyc(); idle();
    iss_valid = 1; iss_addr = 4;
    cyc(); idle();
    iss_valid = 1; iss_addr = 4; wr(0, 4, 32'h77);
    cyc(); idle();
    rd(0, 4);
    sample();
    chk("lit_r4_busy", 64'(rbusy[0]), 64'd1);
    chk("lit_r4_cnt", 64'(busy_cnt), 64'd1);
    chk("lit_r4_data", 64'(rdata[0 +: DW]), 64'h77);
    cyc(); idle();
    wr(0, 4, 32'h78);

    // fill scoreboard
    for (int a = 1; a < 32; a++) begin
      cyc(); idle();
      iss_valid = 1; iss_addr = AW'(a);
    end
    cyc(); idle();
    sample();
    chk("lit_full", 64'(busy_cnt), 64'd31);
    cyc(); idle();
    iss_valid = 1; iss_addr = 0;
    cyc(); idle();
    sample();
    chk("lit_full_r0", 64'(busy_cnt), 64'd31);

    // random traffic, rare resets
    cyc(); idle();
    rst = 1;
    cyc();
    rst = 0;
    for (int n = 0; n < 3000; n++) begin
      idle();
      rst = ($urandom_range(0, 99) == 0);
      we = NW'($urandom);
      for (int i = 0; i < NW; i++) begin
        waddr[i*AW +: AW] = AW'($urandom_range(0, 7) == 0 ? 0 :
                                $urandom_range(0, 31));
        wdata[i*DW +: DW] = $urandom;
      end
      if ($urandom_range(0, 3) == 0) waddr[AW +: AW] = waddr[0 +: AW];
      re = NR'($urandom);
      for (int j = 0; j < NR; j++) begin
        if ($urandom_range(0, 2) == 0)
          raddr[j*AW +: AW] = waddr[($urandom_range(0, NW-1))*AW +: AW];
        else
          raddr[j*AW +: AW] = AW'($urandom_range(0, 31));
      end
      iss_valid = $urandom_range(0, 1);
      iss_addr = ($urandom_range(0, 2) == 0) ? raddr[0 +: AW]
                                              : AW'($urandom_range(0, 31));
      cyc();
    end
    idle();
    rst = 0;
    cyc();
    sample();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port general-purpose register file for the candy CPU, successor to the fixed 2-read/1-write `regfile`. Provides NREAD combinational read ports and NWRITE write ports with deterministic write-conflict priority. An optional write-to-read bypass path is included. An integrated busy scoreboard tracks registers with an outstanding producer, so decode can stall on RAW hazards. Sits between decode (read/issue) and writeback (write/clear).

## Interface
Parameters:
- DATA_W, 32, register width
- ADDR_W, 5, address width; depth = 2**ADDR_W, register 0 hardwired to zero
- NREAD, 2, read port count (1..4)
- NWRITE, 2, write port count (1..2)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- we  in  NWRITE  per-port write enable
- waddr  in  NWRITE*ADDR_W  write addresses, port i at [i*ADDR_W +: ADDR_W]
- wdata  in  NWRITE*DATA_W  write data, port i at [i*DATA_W +: DATA_W]
- re  in  NREAD  per-port read enable
- raddr  in  NREAD*ADDR_W  read addresses, packed as waddr
- rdata  out  NREAD*DATA_W  read data, combinational
- rbusy  out  NREAD  busy flag of raddr[j], combinational
- iss_valid  in  1  issue: mark iss_addr busy
- iss_addr  in  ADDR_W  destination register of issued instruction
- busy_cnt  out  ADDR_W+1  registered popcount of busy bits

## Operation
- Storage: 2**ADDR_W x DATA_W array plus 2**ADDR_W busy bits.
- Write, each edge with rst=0: for each i with we[i]=1 and waddr[i]!=0, reg[waddr[i]] <= wdata[i]. If both ports target the same address, port 1 wins. Writes to address 0 are discarded.
- Read port j, combinational:
  - rst=1 or re[j]=0 or raddr[j]=0 → rdata 0.
  - Otherwise → reg[raddr[j]], subject to the bypass rule in Configuration.
- Scoreboard, next-state per address a != 0:
  - set = iss_valid && iss_addr==a
  - clr = any we[i] && waddr[i]==a
  - busy[a] <= set ? 1 : (clr ? 0 : busy[a]). Issue wins over a same-cycle clear, because the new producer supersedes.
  - busy[0] is always 0; issue to address 0 is ignored.
- rbusy[j]: 0 when rst=1, re[j]=0, or raddr[j]=0. Otherwise busy[raddr[j]], with bypass adjustment.
- busy_cnt = number of set busy bits (registered state), range 0..2**ADDR_W-1.
- Reset: all registers ← 0, all busy ← 0 on the edge where rst=1. A rst assertion mid-sequence discards same-cycle writes and issues.

## Timing
- Write latency: data written at edge N is visible without bypass from the cycle after edge N.
- Read latency: 0 cycles (combinational from raddr/re).
- Scoreboard latency: an issue at edge N sets rbusy from the cycle after edge N; busy_cnt updates on the same edge.
- Output values while rst=1: rdata=0, rbusy=0. busy_cnt=0 from the first cycle after the reset edge.
- No handshake back-pressure. iss_valid and we are accepted unconditionally every cycle.

## Configuration
- REGFILE_BYPASS_EN defined:
  - A read of address a (a!=0, re=1) in the same cycle as a write to a returns that write's wdata. If both write ports hit a, port 1's data is returned.
  - rbusy for a reads 0 when a same-cycle write clears it and no same-cycle issue targets a.
- REGFILE_BYPASS_EN undefined:
  - Reads return array contents only; a same-cycle write is invisible until the next cycle.
  - rbusy reflects the registered busy bit only.

## Test plan
- Reset/zero:
  - Stimulus: write 0xDEADBEEF to r0, then read r0 on both ports.
  - Response: rdata=0, rbusy=0. Then hold rst=1 for one edge after writing r5=0x12: r5 reads 0 and busy_cnt=0.
- Write priority:
  - Stimulus: we=2'b11, both waddr=7, wdata0=0x1111, wdata1=0x2222.
  - Response: next cycle r7 reads 0x2222.
- Bypass:
  - Stimulus: write r3=0xA5A5A5A5 while reading r3 in the same cycle.
  - Response: rdata=0xA5A5A5A5 with REGFILE_BYPASS_EN, old value 0 without. Both builds read 0xA5A5A5A5 the next cycle.
- Scoreboard set/clear:
  - Stimulus: issue r9; next cycle read r9; then write r9=0x55.
  - Response: rbusy=1 and busy_cnt=1 after the issue. After the write edge, rbusy=0 and busy_cnt=0.
- Issue/clear collision:
  - Stimulus: r4 busy, then issue r4 and write r4=0x77 in the same cycle.
  - Response: r4 stays busy (busy_cnt unchanged at 1) and r4 reads 0x77.
- Full scoreboard:
  - Stimulus: issue r1..r31 on consecutive cycles.
  - Response: busy_cnt reaches 31. An issue to r0 leaves it at 31.
